// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-stage PC generator sitting upstream of the BTB.
// Issues fetch_pc/fetch_en each cycle. The BTB result for an issued PC comes
// back one cycle later (stage s1), where it is paired with that PC and offered
// to decode. Redirects come from a BTB predicted-taken or a backend redirect.
// Optional build macro FETCH_PC_GEN_STAT_EN adds prediction/redirect counters.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter int unsigned IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      fetch_pc,
  output logic             fetch_en,
  input  logic             btb_taken,
  input  logic             btb_pre_en,
  input  logic [31:0]      btb_target,
  input  logic [IDX_W-1:0] btb_index,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic             out_taken,
  output logic [31:0]      out_target,
  output logic [IDX_W-1:0] out_index
`ifdef FETCH_PC_GEN_STAT_EN
  ,
  output logic [31:0]      stat_pred_cnt,
  output logic [31:0]      stat_redir_cnt
`endif
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_pc_q, s1_pc_d;

  logic        run;
  logic        pred;
  logic        slot_accept;
  logic [31:0] redir_pc;
  logic [31:0] pred_pc;
  logic [31:0] seq_pc;

  // Low address bits are always discarded; keep them visibly consumed.
  logic        unused_lsbs;
  assign unused_lsbs = ^{ex_target[1:0], btb_target[1:0]};

  assign run         = (state_q == ST_RUN);
  assign pred        = s1_valid_q & btb_pre_en & btb_taken;
  assign redir_pc    = {ex_target[31:2], 2'b00};
  assign pred_pc     = {btb_target[31:2], 2'b00};
  assign seq_pc      = pc_q + 32'd4;

  // A predicted-taken slot blocks new issue so the target can be fetched
  // next cycle; a backend redirect blocks issue and kills the slot.
  assign fetch_en    = run & ~ex_redirect & ~pred & (~s1_valid_q | out_ready);
  assign fetch_pc    = pc_q;

  assign out_valid   = s1_valid_q & ~ex_redirect;
  assign slot_accept = out_valid & out_ready;
  assign out_pc      = s1_pc_q;
  assign out_taken   = pred;
  assign out_target  = s1_valid_q ? pred_pc : '0;
  assign out_index   = s1_valid_q ? btb_index : '0;

  // Boot lasts exactly one cycle regardless of other inputs.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end
  end

  // Next fetch PC: backend redirect, then accepted prediction, then sequential.
  always_comb begin
    pc_d = pc_q;
    if (ex_redirect) begin
      pc_d = redir_pc;
    end else if (pred & out_ready) begin
      pc_d = pred_pc;
    end else if (fetch_en) begin
      pc_d = seq_pc;
    end
  end

  // s1 slot: killed by redirect, refilled on issue, drained on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pc_d    = s1_pc_q;
    if (ex_redirect) begin
      s1_valid_d = 1'b0;
    end else if (fetch_en) begin
      s1_valid_d = 1'b1;
      s1_pc_d    = pc_q;
    end else if (slot_accept) begin
      s1_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
    end
  end

`ifdef FETCH_PC_GEN_STAT_EN
  logic [31:0] pred_cnt_q;
  logic [31:0] redir_cnt_q;

  // Event counters: accepted predictions and backend redirects, free-running.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (pred & out_ready) begin
        pred_cnt_q <= pred_cnt_q + 32'd1;
      end
      if (ex_redirect) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign stat_pred_cnt  = pred_cnt_q;
  assign stat_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: stimulus process updates a transaction-level
// model of the fetch stream and queues expected issues and delivered slots;
// an independent monitor pops and compares when the DUT presents them.
module tb_fetch_pc_gen;
  localparam int unsigned IDX_W = 5;
  localparam logic [31:0] RPC   = 32'h1C00_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      fetch_pc;
  logic             fetch_en;
  logic             btb_taken, btb_pre_en;
  logic [31:0]      btb_target;
  logic [IDX_W-1:0] btb_index;
  logic             ex_redirect;
  logic [31:0]      ex_target;
  logic             out_valid, out_ready, out_taken;
  logic [31:0]      out_pc, out_target;
  logic [IDX_W-1:0] out_index;
`ifdef FETCH_PC_GEN_STAT_EN
  logic [31:0]      stat_pred_cnt, stat_redir_cnt;
`endif

  fetch_pc_gen #(.RESET_PC(RPC), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_pc(fetch_pc), .fetch_en(fetch_en),
    .btb_taken(btb_taken), .btb_pre_en(btb_pre_en),
    .btb_target(btb_target), .btb_index(btb_index),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_taken(out_taken), .out_target(out_target), .out_index(out_index)
`ifdef FETCH_PC_GEN_STAT_EN
    , .stat_pred_cnt(stat_pred_cnt), .stat_redir_cnt(stat_redir_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; logic [31:0] pc; } fetch_rec_t;
  typedef struct {
    int unsigned      cyc;
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    logic [IDX_W-1:0] idx;
  } slot_rec_t;

  fetch_rec_t fq[$];
  slot_rec_t  sq[$];

  int          total = 0;
  int          bad   = 0;
  int unsigned cur_cyc = 0;
  bit          checking = 0;
  bit          skip_wait = 0;

  // Model of the fetch stream: the next address to be fetched, an optional
  // outstanding (fetched, not yet handed to decode) PC, and whether boot ended.
  bit          m_booted;
  logic [31:0] m_next;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  int unsigned m_pred_cnt, m_redir_cnt;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cur_cyc);
    end
  endfunction

  function automatic void model_reset();
    m_booted = 0; m_next = RPC; m_pend = 0; m_pend_pc = '0;
    m_pred_cnt = 0; m_redir_cnt = 0;
  endfunction

  task automatic drive_idle();
    ex_redirect = 0; ex_target = '0; out_ready = 1;
    btb_pre_en = 0; btb_taken = 0; btb_target = '0; btb_index = '0;
  endtask

  // One clock cycle of stimulus; returns with the cycle's outputs settled.
  task automatic step(input logic rd, input logic [31:0] rt, input logic rdy,
                      input logic pe, input logic tk, input logic [31:0] bt,
                      input logic [IDX_W-1:0] bi);
    bit hit, deliver, issue;
    if (!skip_wait) begin
      @(posedge clk); #1;
    end
    skip_wait = 0;
    cur_cyc++;
    ex_redirect = rd; ex_target = rt; out_ready = rdy;
    btb_pre_en = pe; btb_taken = tk; btb_target = bt; btb_index = bi;
    checking = 1;
    hit     = m_pend && pe && tk;
    deliver = m_pend && !rd && rdy;
    issue   = m_booted && !rd && !hit && (!m_pend || rdy);
    if (issue)   fq.push_back('{cyc: cur_cyc, pc: m_next});
    if (deliver) sq.push_back('{cyc: cur_cyc, pc: m_pend_pc, taken: pe & tk,
                                target: {bt[31:2], 2'b00}, idx: bi});
    if (hit && rdy) m_pred_cnt++;
    if (rd) m_redir_cnt++;
    if (rd) begin
      m_next = {rt[31:2], 2'b00};
      m_pend = 0;
    end else if (hit) begin
      if (rdy) begin
        m_next = {bt[31:2], 2'b00};
        m_pend = 0;
      end
    end else if (issue) begin
      m_pend = 1; m_pend_pc = m_next; m_next = m_next + 32'd4;
    end else if (deliver) begin
      m_pend = 0;
    end
    m_booted = 1;
    #2;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    if (!skip_wait) begin
      @(posedge clk); #1;
    end
    checking = 0;
    reset = 1;
    drive_idle();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_fetch_pc", fetch_pc, RPC);
    chk("rst_fetch_en", fetch_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
`ifdef FETCH_PC_GEN_STAT_EN
    chk("rst_stat_pred", stat_pred_cnt, 0);
    chk("rst_stat_redir", stat_redir_cnt, 0);
`endif
    reset = 0;
    model_reset();
    skip_wait = 1;
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  initial begin
    fetch_rec_t f;
    slot_rec_t  s;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("fetch_pc_lsb", fetch_pc[1:0], 2'b00);
        if (fetch_en) begin
          chk("fetch_expected", fq.size() != 0, 1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            chk("fetch_cyc", cur_cyc, f.cyc);
            chk("fetch_pc", fetch_pc, f.pc);
          end
        end
        if (out_valid && out_ready) begin
          chk("slot_expected", sq.size() != 0, 1);
          if (sq.size() != 0) begin
            s = sq.pop_front();
            chk("slot_cyc", cur_cyc, s.cyc);
            chk("out_pc", out_pc, s.pc);
            chk("out_taken", out_taken, s.taken);
            chk("out_target", out_target, s.target);
            chk("out_index", out_index, s.idx);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rt, bt;
    reset = 1;
    drive_idle();
    @(posedge clk); #1;
    do_reset(3);

    // Boot cycle then sequential fetch.
    idle();
    chk("boot_fetch_en", fetch_en, 0);
    chk("boot_fetch_pc", fetch_pc, RPC);
    chk("boot_out_valid", out_valid, 0);
    idle();
    chk("first_fetch", fetch_pc, 32'h1C00_0000);
    idle();
    chk("second_fetch", fetch_pc, 32'h1C00_0004);

    // BTB hit on 1C000004: one bubble, then the target.
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h1C00_0100, 5'd7);
    chk("pred_bubble", fetch_en, 0);
    chk("pred_out_taken", out_taken, 1);
    chk("pred_out_index", out_index, 7);
    idle();
    chk("pred_target_fetch", fetch_pc, 32'h1C00_0100);
    idle();

    // Redirect wins over a same-cycle prediction.
    step(1'b1, 32'h1C00_0203, 1'b1, 1'b1, 1'b1, 32'h1C00_0400, 5'd3);
    chk("redir_out_valid", out_valid, 0);
    chk("redir_fetch_en", fetch_en, 0);
    idle();
    chk("redir_fetch_pc", fetch_pc, 32'h1C00_0200);

    // Decode stall for three cycles.
    repeat (3) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("stall_fetch_en", fetch_en, 0);
      chk("stall_out_pc", out_pc, 32'h1C00_0200);
      chk("stall_fetch_pc", fetch_pc, 32'h1C00_0204);
    end
    idle();
    chk("release_fetch_en", fetch_en, 1);

    // Address wrap at the top of the space.
    step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, '0, '0);
    idle();
    chk("top_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    idle();
    chk("wrap_fetch_pc", fetch_pc, 32'h0000_0000);
    idle();
`ifdef FETCH_PC_GEN_STAT_EN
    chk("stat_pred", stat_pred_cnt, m_pred_cnt);
    chk("stat_redir", stat_redir_cnt, m_redir_cnt);
`endif

    // Reset while a predicted slot is stalled.
    idle();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h2000_0000, 5'd1);
    do_reset(2);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        rt = $urandom;
        if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
        bt = $urandom;
        if ($urandom_range(0, 3) == 0) bt = 32'hFFFF_FFF4 | (bt & 32'h3);
        step(($urandom_range(0, 15) == 0), rt, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), bt,
             IDX_W'($urandom));
      end
    end
    repeat (4) idle();
`ifdef FETCH_PC_GEN_STAT_EN
    chk("rand_stat_pred", stat_pred_cnt, m_pred_cnt);
    chk("rand_stat_redir", stat_redir_cnt, m_redir_cnt);
`endif
    #5;
    chk("fetch_q_drained", fq.size(), 0);
    chk("slot_q_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
